// File: rtl/seq_arbiter.sv
// Round-robin arbiter that grants whole LEN-item sequences from N streams.
// Grants are limited by downstream credits that only fin returns.
module seq_arbiter #(
  parameter int N       = 2,
  parameter int LEN     = 4,
  parameter int W       = 8,
  parameter int CREDITS = 2,
  localparam int SW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1,
  localparam int KW = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N*W-1:0] idat,
  input  logic [N-1:0]  ivld,
  output logic [N-1:0]  irdy,
  output logic [W-1:0]  odat,
  output logic [SW-1:0] osrc,
  output logic          olast,
  output logic          ovld,
  input  logic          ordy,
  input  logic          fin
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] prio_q, prio_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] credit_q, credit_d;

  logic [SW-1:0] pick;
  logic          found;
  logic          grant;
  logic          fin_ok;
  logic          act;
  logic          last;
  logic          xfer;
  logic          vld_sel;
  logic [W-1:0]  dat_sel;

  // Distance from the stream after prio; smallest requesting distance wins.
  always_comb begin
    int best;
    int d;
    best  = N;
    d     = 0;
    pick  = '0;
    for (int j = 0; j < N; j++) begin
      d = (j + N - 1 - int'(prio_q)) % N;
      if (ivld[j] && d < best) begin
        best = d;
        pick = SW'(j);
      end
    end
    found = (best < N);
  end

  always_comb begin
    vld_sel = 1'b0;
    dat_sel = '0;
    for (int j = 0; j < N; j++) begin
      if (sel_q == SW'(j)) begin
        vld_sel = ivld[j];
        dat_sel = idat[j*W +: W];
      end
    end
  end

  assign act    = (state_q == GRANT) && !rst;
  assign last   = (cnt_q == CW'(LEN - 1));
  assign ovld   = act && vld_sel;
  assign odat   = act ? dat_sel : '0;
  assign osrc   = act ? sel_q : '0;
  assign olast  = ovld && last;
  assign xfer   = ovld && ordy;
  assign grant  = (state_q == IDLE) && (credit_q != '0) && found;
  assign fin_ok = fin && (credit_q != KW'(CREDITS));

  always_comb begin
    irdy = '0;
    for (int j = 0; j < N; j++) begin
      irdy[j] = act && ordy && (sel_q == SW'(j));
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          sel_d   = pick;
          prio_d  = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          if (last) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    credit_d = credit_q;
    unique case ({grant, fin_ok})
      2'b10:   credit_d = credit_q - KW'(1);
      2'b01:   credit_d = credit_q + KW'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      prio_q   <= SW'(N - 1);
      cnt_q    <= '0;
      credit_q <= KW'(CREDITS);
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      prio_q   <= prio_d;
      cnt_q    <= cnt_d;
      credit_q <= credit_d;
    end
  end

  // A fin with every credit already home means downstream miscounted.
  always_ff @(posedge clk) begin
    if (!rst && fin) begin
      assert (credit_q != KW'(CREDITS));
    end
  end

endmodule
